// File: rtl/week6_ex1_xor_accum_if.sv
// rtl/week6_ex1_xor_accum_if.sv - word stream in / frame result out bundle for the XOR accumulator
interface week6_ex1_xor_accum_if #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CW-1:0]    out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_count
    );
endinterface

// File: rtl/week6_ex1_xor_accum.sv
// rtl/week6_ex1_xor_accum.sv - XORs up to FRAME_LEN words per frame and holds the result until taken
module week6_ex1_xor_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    week6_ex1_xor_accum_if.slave   bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;
    logic             accept;
    logic             close;

    // cnt only advances while below FRAME_LEN, so cnt+1 never wraps
    always_comb begin
        accept   = (state == ACCUM) && bus.in_valid && bus.in_ready;
        acc_next = acc ^ bus.in_data;
        cnt_next = cnt + 1'b1;
        close    = accept && (bus.in_last || (cnt_next == CW'(FRAME_LEN)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ACCUM;
            acc            <= '0;
            cnt            <= '0;
            bus.in_ready   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_parity <= 1'b0;
            bus.out_count  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    // in_ready stays low in reset and rises on the first edge after it
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                    end
                    if (close) begin
                        state          <= HOLD;
                        bus.in_ready   <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= acc_next;
                        bus.out_parity <= ^acc_next;
                        bus.out_count  <= cnt_next;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state          <= ACCUM;
                        acc            <= '0;
                        cnt            <= '0;
                        bus.in_ready   <= 1'b1;
                        bus.out_valid  <= 1'b0;
                        bus.out_data   <= '0;
                        bus.out_parity <= 1'b0;
                        bus.out_count  <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_week6_ex1_xor_accum.sv
// tb/tb_week6_ex1_xor_accum.sv - randomized and directed bench for week6_ex1_xor_accum
module tb_week6_ex1_xor_accum;
    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CW        = $clog2(FRAME_LEN + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    logic [WIDTH-1:0] exp_x;
    int               exp_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    week6_ex1_xor_accum_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus ();

    week6_ex1_xor_accum #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic model_par(input logic [WIDTH-1:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    // Offers a word from a negedge until taken; updates the frame model on acceptance.
    task automatic drive_word(input logic [WIDTH-1:0] d, input logic l);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (ok) begin
            exp_x = exp_x ^ d;
            exp_n = exp_n + 1;
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: word %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic idle_cycle(input logic junk_last);
        bus.in_valid = 1'b0;
        bus.in_last  = junk_last;
        bus.in_data  = WIDTH'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.in_last  = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_x = '0;
        exp_n = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        exp_x = '0; exp_n = 0;
        #2;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: got %b required 0",
                {bus.in_ready, bus.out_valid, bus.out_data, bus.out_parity, bus.out_count}); end
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_count} !== '0)
            begin miscompares++; $display("FAIL reset_held: got %b required 0",
                {bus.in_ready, bus.out_valid, bus.out_count}); end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0)
            begin miscompares++; $display("FAIL ready_before_edge: got %b required 0", bus.in_ready); end
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            begin miscompares++; $display("FAIL ready_after_edge: got %b required 10", {bus.in_ready, bus.out_valid}); end
    endtask

    task automatic test_full_frame();
        drive_word(8'h0F, 1'b0);
        drive_word(8'hF0, 1'b0);
        drive_word(8'hFF, 1'b0);
        drive_word(8'h00, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count} !== {2'b10, 8'h00, 1'b0, 3'd4})
            begin miscompares++; $display("FAIL full_frame: got v=%b r=%b d=%h p=%b c=%0d required v=1 r=0 d=00 p=0 c=4",
                bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count); end
        handshake();
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count} !== {2'b01, 8'h00, 1'b0, 3'd0})
            begin miscompares++; $display("FAIL accum_zero: got v=%b r=%b d=%h p=%b c=%0d required v=0 r=1 zeros",
                bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count); end
    endtask

    task automatic test_early_close();
        drive_word(8'h01, 1'b0);
        drive_word(8'h03, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== {1'b1, 8'h02, 1'b1, 3'd2})
            begin miscompares++; $display("FAIL early_close: got v=%b d=%h p=%b c=%0d required v=1 d=02 p=1 c=2",
                bus.out_valid, bus.out_data, bus.out_parity, bus.out_count); end
        handshake();
    endtask

    task automatic test_single_word();
        drive_word(8'hA5, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== {1'b1, 8'hA5, 1'b0, 3'd1})
            begin miscompares++; $display("FAIL single_word: got v=%b d=%h p=%b c=%0d required v=1 d=a5 p=0 c=1",
                bus.out_valid, bus.out_data, bus.out_parity, bus.out_count); end
        handshake();
    endtask

    task automatic test_backpressure();
        drive_word(8'h5A, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count} !== {2'b10, 8'h5A, 1'b0, 3'd1})
                begin miscompares++; $display("FAIL hold_stable[%0d]: got v=%b r=%b d=%h p=%b c=%0d required v=1 r=0 d=5a p=0 c=1",
                    i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count); end
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        handshake();
        drive_word(8'h3C, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_count} !== {1'b1, 8'h3C, 3'd1})
            begin miscompares++; $display("FAIL after_backpressure: got v=%b d=%h c=%0d required v=1 d=3c c=1",
                bus.out_valid, bus.out_data, bus.out_count); end
        handshake();
    endtask

    task automatic test_reset_mid_frame();
        drive_word(8'h11, 1'b0);
        drive_word(8'h22, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== '0)
            begin miscompares++; $display("FAIL async_reset: got %b required 0",
                {bus.in_ready, bus.out_valid, bus.out_data, bus.out_parity, bus.out_count}); end
        #1 rst_n = 1'b1;
        exp_x = '0; exp_n = 0;
        @(negedge clk);
        drive_word(8'h33, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_count} !== {1'b1, 8'h33, 3'd1})
            begin miscompares++; $display("FAIL after_reset: got v=%b d=%h c=%0d required v=1 d=33 c=1",
                bus.out_valid, bus.out_data, bus.out_count); end
        handshake();
    endtask

    task automatic test_gapped();
        drive_word(8'h80, 1'b0);
        idle_cycle(1'b1);
        drive_word(8'h01, 1'b0);
        idle_cycle(1'b1);
        drive_word(8'h02, 1'b0);
        idle_cycle(1'b0);
        drive_word(8'h04, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== {1'b1, 8'h87, 1'b0, 3'd4})
            begin miscompares++; $display("FAIL gapped: got v=%b d=%h p=%b c=%0d required v=1 d=87 p=0 c=4",
                bus.out_valid, bus.out_data, bus.out_parity, bus.out_count); end
        handshake();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 25; f++) begin
            int len = $urandom_range(1, FRAME_LEN);
            for (int i = 0; i < len; i++) begin
                logic lst = (i == len - 1) && ((len < FRAME_LEN) || ($urandom_range(0, 1) == 1));
                if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
                drive_word(WIDTH'($urandom), lst);
            end
            for (int s = 0; s <= $urandom_range(0, 3); s++) begin
                vectors++;
                if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count} !==
                    {2'b10, exp_x, model_par(exp_x), CW'(exp_n)})
                    begin miscompares++; $display("FAIL rand_frame[%0d]: got v=%b r=%b d=%h p=%b c=%0d required v=1 r=0 d=%h p=%b c=%0d",
                        f, bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_count,
                        exp_x, model_par(exp_x), exp_n); end
                if (s < 3) begin
                    bus.in_valid = 1'($urandom); bus.in_data = WIDTH'($urandom); bus.in_last = 1'($urandom);
                    @(posedge clk); @(negedge clk);
                    bus.in_valid = 1'b0; bus.in_last = 1'b0;
                end
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        int start_cyc, exp_cycles = 0;
        bus.out_ready = 1'b1;
        start_cyc = cyc;
        for (int f = 0; f < 5; f++) begin
            int len = $urandom_range(1, FRAME_LEN);
            exp_cycles += len + 1;
            for (int i = 0; i < len; i++)
                drive_word(WIDTH'($urandom), i == len - 1);
            vectors++;
            if ({bus.out_valid, bus.out_data, bus.out_parity, bus.out_count} !== {1'b1, exp_x, model_par(exp_x), CW'(exp_n)})
                begin miscompares++; $display("FAIL b2b_frame[%0d]: got v=%b d=%h p=%b c=%0d required v=1 d=%h p=%b c=%0d",
                    f, bus.out_valid, bus.out_data, bus.out_parity, bus.out_count, exp_x, model_par(exp_x), exp_n); end
            exp_x = '0; exp_n = 0;
        end
        @(negedge clk);
        vectors++;
        if (cyc - start_cyc !== exp_cycles)
            begin miscompares++; $display("FAIL b2b_throughput: got %0d cycles required %0d", cyc - start_cyc, exp_cycles); end
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            begin miscompares++; $display("FAIL b2b_end_state: got %b required 01", {bus.out_valid, bus.in_ready}); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_early_close();
        test_single_word();
        test_backpressure();
        test_reset_mid_frame();
        test_gapped();
        test_random_frames();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
